dmem_arbiter: RTL and testbench

- Shares the single-port 1024x32 data memory between two requesters: port A (pipeline MEM stage) and port B (loader/debug DMA).
- Performs at most one memory access per cycle. Write enable to the memory is combinational. Read data and errors are returned registered, one cycle after the grant.
- Arbitration is CPU-priority with a starvation guard for B, or pure round-robin, selected by parameter.
- Sits between the pipeline/loader and the data memory. The pipeline treats a_gnt=0 while a_req=1 as a stall.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: pipeline MEM stage (A)
// and loader/debug DMA (B). One access per cycle, responses returned registered.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [31:0]       a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [31:0]       a_rdata_o,
  output logic              a_err_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [31:0]       b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [31:0]       b_rdata_o,
  output logic              b_err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic              LG_A       = 1'b0;
  localparam logic              LG_B       = 1'b1;

  logic        last_grant_q, last_grant_d;
  logic [3:0]  wait_b_q, wait_b_d;
  logic        a_rvalid_q, a_rvalid_d, a_err_q, a_err_d;
  logic        b_rvalid_q, b_rvalid_d, b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic a_gnt, b_gnt;
  logic a_in_range, b_in_range;

  // Full-width compare: any set upper address bit makes the access out of range.
  assign a_in_range = (a_addr_i < DEPTH_A);
  assign b_in_range = (b_addr_i < DEPTH_A);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (a_req_i && b_req_i) begin
        if (RR_MODE != 0) begin
          if (last_grant_q == LG_A) b_gnt = 1'b1;
          else                      a_gnt = 1'b1;
        end else if (wait_b_q == MAX_WAIT_C) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req_i;
        b_gnt = b_req_i;
      end
    end
  end

  assign a_gnt_o     = a_gnt;
  assign b_gnt_o     = b_gnt;
  assign mem_addr_o  = b_gnt ? b_addr_i  : a_addr_i;
  assign mem_wdata_o = b_gnt ? b_wdata_i : a_wdata_i;
  assign mem_we_o    = (a_gnt & a_we_i & a_in_range) | (b_gnt & b_we_i & b_in_range);

  always_comb begin
    last_grant_d = last_grant_q;
    if (a_gnt) last_grant_d = LG_A;
    if (b_gnt) last_grant_d = LG_B;

    wait_b_d = 4'd0;
    if (b_req_i && !b_gnt)
      wait_b_d = (wait_b_q == MAX_WAIT_C) ? wait_b_q : wait_b_q + 4'd1;

    a_rvalid_d = a_gnt & ~a_we_i & a_in_range;
    a_err_d    = a_gnt & ~a_in_range;
    a_rdata_d  = a_rvalid_d ? mem_rdata_i : a_rdata_q;
    b_rvalid_d = b_gnt & ~b_we_i & b_in_range;
    b_err_d    = b_gnt & ~b_in_range;
    b_rdata_d  = b_rvalid_d ? mem_rdata_i : b_rdata_q;
  end

  // last_grant resets to B so that A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= LG_B;
      wait_b_q     <= 4'd0;
      a_rvalid_q   <= 1'b0;
      a_err_q      <= 1'b0;
      a_rdata_q    <= 32'd0;
      b_rvalid_q   <= 1'b0;
      b_err_q      <= 1'b0;
      b_rdata_q    <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_b_q     <= wait_b_d;
      a_rvalid_q   <= a_rvalid_d;
      a_err_q      <= a_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rvalid_q   <= b_rvalid_d;
      b_err_q      <= b_err_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign a_err_o    = a_err_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rvalid_o = b_rvalid_q;
  assign b_err_o    = b_err_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-cycle vectors plus hand-written
// contention and asynchronous-reset sequences; a second instance runs round-robin.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        r_a_gnt, r_a_rvalid, r_a_err, r_b_gnt, r_b_rvalid, r_b_err, r_mem_we;
  logic [31:0] r_a_rdata, r_b_rdata, r_mem_addr, r_mem_wdata;
  logic [31:0] r_mem_rdata;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [31:0] mem [1024];

  dmem_arbiter #(.ADDR_W(32), .DEPTH(1024), .RR_MODE(0), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DEPTH(1024), .RR_MODE(1), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(r_a_gnt), .a_rvalid_o(r_a_rvalid), .a_rdata_o(r_a_rdata), .a_err_o(r_a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(r_b_gnt), .b_rvalid_o(r_b_rvalid), .b_rdata_o(r_b_rdata), .b_err_o(r_b_err),
    .mem_we_o(r_mem_we), .mem_addr_o(r_mem_addr), .mem_wdata_o(r_mem_wdata),
    .mem_rdata_i(r_mem_rdata)
  );

  assign r_mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory fixture: preloaded while in reset, written on mem_we, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      mem[5]    <= 32'hA5A5A5A5;
      mem[7]    <= 32'h00000000;
      mem[32]   <= 32'h00000005;
      mem[1023] <= 32'h00000000;
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hBAD0BAD0;

  typedef struct {
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        e_a_gnt, e_b_gnt, e_mem_we;
    logic [31:0] e_mem_addr;
    logic        e_a_rvalid, e_a_err;
    logic [31:0] e_a_rdata;
    logic        e_b_rvalid, e_b_err;
    logic [31:0] e_b_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic chk1(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Registered expectations are the responses to the previous row's grant.
    //           a_req a_we  a_addr        a_wdata        b_req b_we  b_addr        b_wdata        agnt  bgnt  we    mem_addr      arv   aerr  a_rdata        brv   berr  b_rdata
    vecs[0]  = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 32'd32,       32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b0, 32'd32,       1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 32'd7,        32'hDEADBEEF,  1'b0, 1'b1, 1'b1, 32'd7,        1'b1, 1'b0, 32'h00000005, 1'b0, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd7,        32'd0,         1'b0, 1'b1, 1'b0, 32'd7,        1'b0, 1'b0, 32'h00000005, 1'b0, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b1, 32'd1024,     32'h11111111,  1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b0, 32'd1024,     1'b0, 1'b0, 32'h00000005, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'h00000005, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'd1023,     32'hCAFEF00D,  1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b1, 32'd1023,     1'b0, 1'b1, 32'h00000005, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'd1023,     32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b0, 32'd1023,     1'b0, 1'b0, 32'h00000005, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd1023,     32'd0,         1'b0, 1'b1, 1'b0, 32'd1023,     1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd1024,     32'd0,         1'b0, 1'b1, 1'b0, 32'd1024,     1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[12] = '{1'b1, 1'b1, 32'h00010005, 32'h12345678,  1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 1'b0, 32'h00010005, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 1'b0, 32'd5,        32'd0,         1'b1, 1'b0, 32'd7,        32'd0,         1'b1, 1'b0, 1'b0, 32'd5,        1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[14] = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd7,        32'd0,         1'b0, 1'b1, 1'b0, 32'd7,        1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF};

    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors_applied++;
    chk1("reset_a_gnt", a_gnt, 1'b0);
    chk1("reset_mem_we", mem_we, 1'b0);
    $display("reset hold a_gnt=%b mem_we=%b", a_gnt, mem_we);
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      #1;
      vectors_applied++;
      chk1 ($sformatf("v%0d a_gnt", i),    a_gnt,    vecs[i].e_a_gnt);
      chk1 ($sformatf("v%0d b_gnt", i),    b_gnt,    vecs[i].e_b_gnt);
      chk1 ($sformatf("v%0d mem_we", i),   mem_we,   vecs[i].e_mem_we);
      chk32($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      chk1 ($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].e_a_rvalid);
      chk1 ($sformatf("v%0d a_err", i),    a_err,    vecs[i].e_a_err);
      chk32($sformatf("v%0d a_rdata", i),  a_rdata,  vecs[i].e_a_rdata);
      chk1 ($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].e_b_rvalid);
      chk1 ($sformatf("v%0d b_err", i),    b_err,    vecs[i].e_b_err);
      chk32($sformatf("v%0d b_rdata", i),  b_rdata,  vecs[i].e_b_rdata);
      $display("vec %0d gnt=%b%b we=%b addr=%h a:%b/%b/%h b:%b/%b/%h", i, a_gnt, b_gnt,
               mem_we, mem_addr, a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata);
    end

    // Continuous contention, priority mode: A,A,A,A,B repeating.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd32;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd7;
      #1;
      vectors_applied++;
      chk1($sformatf("prio%0d a_gnt", i), a_gnt, (i % 5) != 4);
      chk1($sformatf("prio%0d b_gnt", i), b_gnt, (i % 5) == 4);
      $display("prio cycle %0d a_gnt=%b b_gnt=%b", i, a_gnt, b_gnt);
    end

    // Asynchronous reset in the middle of a granted read.
    @(negedge clk);
    b_req = 1'b0;
    @(posedge clk);
    #2;
    vectors_applied++;
    chk1("pre_rst a_gnt", a_gnt, 1'b1);
    chk1("pre_rst a_rvalid", a_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    vectors_applied++;
    chk1 ("async_rst a_gnt", a_gnt, 1'b0);
    chk1 ("async_rst a_rvalid", a_rvalid, 1'b0);
    chk1 ("async_rst a_err", a_err, 1'b0);
    chk1 ("async_rst mem_we", mem_we, 1'b0);
    chk32("async_rst a_rdata", a_rdata, 32'h0);
    $display("async reset a_gnt=%b a_rvalid=%b a_err=%b mem_we=%b", a_gnt, a_rvalid, a_err, mem_we);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Contention after release: A first in both modes, then round-robin alternates.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd32;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd7;
      #1;
      vectors_applied++;
      if (i == 0) begin
        chk1("post_rst a_rvalid", a_rvalid, 1'b0);
        chk1("post_rst a_err", a_err, 1'b0);
      end
      chk1($sformatf("post%0d prio a_gnt", i), a_gnt, (i % 5) != 4);
      chk1($sformatf("rr%0d a_gnt", i), r_a_gnt, (i % 2) == 0);
      chk1($sformatf("rr%0d b_gnt", i), r_b_gnt, (i % 2) == 1);
      $display("post-reset cycle %0d prio a_gnt=%b rr gnt=%b%b", i, a_gnt, r_a_gnt, r_b_gnt);
    end

    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
